// File: rtl/nec_ir_pkg.sv
// Shared types and constants for the NEC IR receiver: FSM states, error codes,
// nominal pulse widths and the tolerance-window helpers.
package nec_ir_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLeadMark,
    StLeadSpace,
    StBitMark,
    StBitSpace,
    StRepMark,
    StRecover
  } nec_state_e;

  localparam logic [7:0] ERR_NONE       = 8'd0;
  localparam logic [7:0] ERR_LEAD_MARK  = 8'd1;
  localparam logic [7:0] ERR_LEAD_SPACE = 8'd2;
  localparam logic [7:0] ERR_BIT_MARK   = 8'd3;
  localparam logic [7:0] ERR_BIT_SPACE  = 8'd4;
  localparam logic [7:0] ERR_TIMEOUT    = 8'd5;
  localparam logic [7:0] ERR_CHECKSUM   = 8'd6;

  localparam int unsigned NOM_LEAD_MARK_US  = 9000;
  localparam int unsigned NOM_DATA_SPACE_US = 4500;
  localparam int unsigned NOM_REP_SPACE_US  = 2250;
  localparam int unsigned NOM_BIT_MARK_US   = 560;
  localparam int unsigned NOM_ZERO_SPACE_US = 560;
  localparam int unsigned NOM_ONE_SPACE_US  = 1690;

  // Lower (upper=0) or upper (upper=1) inclusive bound of the window around nom.
  function automatic logic [15:0] win_bound(int unsigned nom, int unsigned tol_pct,
                                            logic upper);
    int unsigned b;
    b = upper ? (nom * (100 + tol_pct)) / 100 : (nom * (100 - tol_pct)) / 100;
    return b[15:0];
  endfunction

  function automatic logic in_win(logic [15:0] w, logic [15:0] lo, logic [15:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// Synchronises the raw IR line, detects edges and measures the time since the
// last edge in microseconds with a saturating 16-bit counter.
module ir_pulse_timer #(
  parameter int unsigned CLOCK_FREQ_MHZ = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ir,
  output logic        level,
  output logic        rise,
  output logic        fall,
  output logic [15:0] width_us
);

  localparam int unsigned PrescW = (CLOCK_FREQ_MHZ > 1) ? $clog2(CLOCK_FREQ_MHZ) : 1;
  localparam logic [PrescW-1:0] PrescMax = PrescW'(CLOCK_FREQ_MHZ - 1);

  logic [1:0]        sync_q;
  logic              prev_q;
  logic [PrescW-1:0] presc_q;
  logic [15:0]       width_q;
  logic              us_tick;
  logic              edge_det;

  assign level    = sync_q[1];
  assign rise     = sync_q[1] & ~prev_q;
  assign fall     = ~sync_q[1] & prev_q;
  assign edge_det = rise | fall;
  assign us_tick  = (presc_q == PrescMax);
  assign width_us = width_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      presc_q <= '0;
      width_q <= '0;
    end else begin
      sync_q <= {sync_q[0], ir};
      prev_q <= sync_q[1];
      // Restarting the prescaler on each edge keeps the width aligned to the edge.
      if (edge_det) begin
        presc_q <= '0;
        width_q <= '0;
      end else begin
        presc_q <= us_tick ? '0 : presc_q + PrescW'(1);
        if (us_tick && (width_q != 16'hFFFF)) begin
          width_q <= width_q + 16'd1;
        end
      end
    end
  end

endmodule

// File: rtl/nec_ir_rx.sv
// NEC infrared frame receiver: decodes leader, 32 data bits and repeat codes.
// Define NEC_CHECK_EN to reject frames whose last byte is not the inverse of the third.
module nec_ir_rx
  import nec_ir_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ_MHZ = 50,
  parameter int unsigned TOLERANCE_PCT  = 25,
  parameter int unsigned TIMEOUT_US     = 12000,
  parameter int unsigned GAP_US         = 10000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ir,
  output logic [31:0] o_data,
  output logic        o_idle,
  output logic        o_data_ready,
  output logic        o_repeat,
  output logic [7:0]  o_error_code
);

  localparam logic [15:0] LeadMarkLo  = win_bound(NOM_LEAD_MARK_US, TOLERANCE_PCT, 1'b0);
  localparam logic [15:0] LeadMarkHi  = win_bound(NOM_LEAD_MARK_US, TOLERANCE_PCT, 1'b1);
  localparam logic [15:0] DataSpaceLo = win_bound(NOM_DATA_SPACE_US, TOLERANCE_PCT, 1'b0);
  localparam logic [15:0] DataSpaceHi = win_bound(NOM_DATA_SPACE_US, TOLERANCE_PCT, 1'b1);
  localparam logic [15:0] RepSpaceLo  = win_bound(NOM_REP_SPACE_US, TOLERANCE_PCT, 1'b0);
  localparam logic [15:0] RepSpaceHi  = win_bound(NOM_REP_SPACE_US, TOLERANCE_PCT, 1'b1);
  localparam logic [15:0] BitMarkLo   = win_bound(NOM_BIT_MARK_US, TOLERANCE_PCT, 1'b0);
  localparam logic [15:0] BitMarkHi   = win_bound(NOM_BIT_MARK_US, TOLERANCE_PCT, 1'b1);
  localparam logic [15:0] ZeroLo      = win_bound(NOM_ZERO_SPACE_US, TOLERANCE_PCT, 1'b0);
  localparam logic [15:0] ZeroHi      = win_bound(NOM_ZERO_SPACE_US, TOLERANCE_PCT, 1'b1);
  localparam logic [15:0] OneLo       = win_bound(NOM_ONE_SPACE_US, TOLERANCE_PCT, 1'b0);
  localparam logic [15:0] OneHi       = win_bound(NOM_ONE_SPACE_US, TOLERANCE_PCT, 1'b1);
  localparam logic [15:0] TimeoutW    = TIMEOUT_US[15:0];
  localparam logic [15:0] GapW        = GAP_US[15:0];

  logic        level;
  logic        rise;
  logic        fall;
  logic [15:0] width_us;

  ir_pulse_timer #(
    .CLOCK_FREQ_MHZ(CLOCK_FREQ_MHZ)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .ir      (ir),
    .level   (level),
    .rise    (rise),
    .fall    (fall),
    .width_us(width_us)
  );

  nec_state_e  state_q;
  logic [31:0] shift_q;
  logic [31:0] data_q;
  logic [5:0]  bit_cnt_q;
  logic        frame_valid_q;
  logic        data_ready_q;
  logic        repeat_q;
  logic [7:0]  err_code_q;

  logic       in_lead_mark;
  logic       in_data_space;
  logic       in_rep_space;
  logic       in_bit_mark;
  logic       in_zero;
  logic       in_one;
  logic       timed_out;
  logic       csum_bad;
  logic [7:0] err;

  assign in_lead_mark  = in_win(width_us, LeadMarkLo, LeadMarkHi);
  assign in_data_space = in_win(width_us, DataSpaceLo, DataSpaceHi);
  assign in_rep_space  = in_win(width_us, RepSpaceLo, RepSpaceHi);
  assign in_bit_mark   = in_win(width_us, BitMarkLo, BitMarkHi);
  assign in_zero       = in_win(width_us, ZeroLo, ZeroHi);
  assign in_one        = in_win(width_us, OneLo, OneHi);

  assign timed_out = (state_q != StIdle) && (state_q != StRecover) && (width_us >= TimeoutW);

`ifdef NEC_CHECK_EN
  assign csum_bad = (shift_q[15:8] != ~shift_q[7:0]);
`else
  assign csum_bad = 1'b0;
`endif

  // Error code raised this cycle; a timeout outranks whatever edge arrives with it.
  always_comb begin
    err = ERR_NONE;
    if (timed_out) begin
      err = ERR_TIMEOUT;
    end else begin
      case (state_q)
        StLeadMark: begin
          if (rise && !in_lead_mark) err = ERR_LEAD_MARK;
        end
        StLeadSpace: begin
          if (fall && !in_data_space && !in_rep_space) err = ERR_LEAD_SPACE;
        end
        StBitMark: begin
          if (rise) begin
            if (!in_bit_mark) begin
              err = ERR_BIT_MARK;
            end else if ((bit_cnt_q == 6'd32) && csum_bad) begin
              err = ERR_CHECKSUM;
            end
          end
        end
        StBitSpace: begin
          if (fall && !in_zero && !in_one) err = ERR_BIT_SPACE;
        end
        StRepMark: begin
          if (rise && !in_bit_mark) err = ERR_BIT_MARK;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      shift_q       <= '0;
      data_q        <= '0;
      bit_cnt_q     <= '0;
      frame_valid_q <= 1'b0;
      data_ready_q  <= 1'b0;
      repeat_q      <= 1'b0;
      err_code_q    <= ERR_NONE;
    end else begin
      data_ready_q <= 1'b0;
      repeat_q     <= 1'b0;
      if (err != ERR_NONE) begin
        err_code_q    <= err;
        frame_valid_q <= 1'b0;
        shift_q       <= '0;
        bit_cnt_q     <= '0;
        state_q       <= StRecover;
      end else begin
        case (state_q)
          StIdle: begin
            if (fall) state_q <= StLeadMark;
          end
          StLeadMark: begin
            if (rise) state_q <= StLeadSpace;
          end
          StLeadSpace: begin
            if (fall) begin
              if (in_data_space) begin
                bit_cnt_q <= '0;
                state_q   <= StBitMark;
              end else begin
                state_q <= StRepMark;
              end
            end
          end
          StBitMark: begin
            if (rise) begin
              if (bit_cnt_q == 6'd32) begin
                data_q        <= shift_q;
                data_ready_q  <= 1'b1;
                err_code_q    <= ERR_NONE;
                frame_valid_q <= 1'b1;
                shift_q       <= '0;
                bit_cnt_q     <= '0;
                state_q       <= StIdle;
              end else begin
                state_q <= StBitSpace;
              end
            end
          end
          StBitSpace: begin
            if (fall) begin
              shift_q   <= {shift_q[30:0], in_one};
              bit_cnt_q <= bit_cnt_q + 6'd1;
              state_q   <= StBitMark;
            end
          end
          StRepMark: begin
            if (rise) begin
              repeat_q <= frame_valid_q;
              state_q  <= StIdle;
            end
          end
          StRecover: begin
            // width_us restarts on every edge, so this is continuous high time.
            if (level && (width_us >= GapW)) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign o_data       = data_q;
  assign o_idle       = (state_q == StIdle);
  assign o_data_ready = data_ready_q;
  assign o_repeat     = repeat_q;
  assign o_error_code = err_code_q;

endmodule

// File: tb/tb_nec_ir_rx.sv
// Self-checking bench for nec_ir_rx: NEC frames with random content and pulse jitter.
module tb_nec_ir_rx;

  localparam int unsigned FreqMhz = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ir = 1'b1;
  logic [31:0] o_data;
  logic        o_idle;
  logic        o_data_ready;
  logic        o_repeat;
  logic [7:0]  o_error_code;

  always #5 clk = ~clk;

  nec_ir_rx #(
    .CLOCK_FREQ_MHZ(FreqMhz),
    .TOLERANCE_PCT (25),
    .TIMEOUT_US    (12000),
    .GAP_US        (10000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ir          (ir),
    .o_data      (o_data),
    .o_idle      (o_idle),
    .o_data_ready(o_data_ready),
    .o_repeat    (o_repeat),
    .o_error_code(o_error_code)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_cnt = 0;
  int rep_cnt = 0;
  int both_cnt = 0;
  int ready_cyc = 0;
  logic [31:0] exp_data = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_data_ready) begin
      ready_cnt <= ready_cnt + 1;
      ready_cyc <= cyc;
    end
    if (o_repeat) rep_cnt <= rep_cnt + 1;
    if (o_data_ready && o_repeat) both_cnt <= both_cnt + 1;
  end

  task automatic wait_us(input int unsigned us);
    repeat (us * FreqMhz) @(negedge clk);
  endtask

  function automatic int unsigned jit(input int unsigned nom, input int unsigned pct);
    if (pct == 0) return nom;
    return (nom * (100 - pct + $urandom_range(2 * pct))) / 100;
  endfunction

  task automatic pulse(input int unsigned mark, input int unsigned space);
    ir = 1'b0;
    wait_us(mark);
    ir = 1'b1;
    wait_us(space);
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Reference model: bytes go out LSB first and the first bit on air lands in [31].
  function automatic logic [31:0] nec_word(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3);
    return {rev8(b0), rev8(b1), rev8(b2), rev8(b3)};
  endfunction

  // Sends leader and nbits bits; a full frame adds the stop mark, otherwise the
  // line is left low partway into the next bit mark.
  task automatic send_frame(input logic [31:0] word, input int unsigned pct, input int nbits,
                            output int stop_cyc);
    stop_cyc = 0;
    pulse(jit(9000, pct), jit(4500, pct));
    for (int i = 0; i < nbits; i++) begin
      pulse(jit(560, pct), word[31-i] ? jit(1690, pct) : jit(560, pct));
    end
    if (nbits < 32) begin
      ir = 1'b0;
      wait_us(200);
    end else begin
      stop_cyc = cyc;
      ir = 1'b0;
      wait_us(jit(560, pct));
      ir = 1'b1;
      wait_us(1000);
    end
  endtask

  task automatic send_repeat(input int unsigned pct);
    pulse(jit(9000, pct), jit(2250, pct));
    ir = 1'b0;
    wait_us(jit(560, pct));
    ir = 1'b1;
    wait_us(500);
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (o_data !== 32'h0) begin
      errors++;
      $display("FAIL %s o_data: got %h want 00000000", tag, o_data);
    end
    checks++;
    if (o_idle !== 1'b1) begin
      errors++;
      $display("FAIL %s o_idle: got %b want 1", tag, o_idle);
    end
    checks++;
    if (o_data_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s o_data_ready: got %b want 0", tag, o_data_ready);
    end
    checks++;
    if (o_repeat !== 1'b0) begin
      errors++;
      $display("FAIL %s o_repeat: got %b want 0", tag, o_repeat);
    end
    checks++;
    if (o_error_code !== 8'd0) begin
      errors++;
      $display("FAIL %s o_error_code: got %0d want 0", tag, o_error_code);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    wait_us(100);
  endtask

  task automatic test_directed_frame;
    int r0;
    int stop_cyc;
    int lat;
    r0 = ready_cnt;
    send_frame(nec_word(8'h00, 8'hFF, 8'h12, 8'hED), 0, 32, stop_cyc);
    exp_data = 32'h00FF48B7;
    lat = ready_cyc - stop_cyc;
    checks++;
    if (ready_cnt - r0 != 1) begin
      errors++;
      $display("FAIL directed ready count: got %0d want 1", ready_cnt - r0);
    end
    checks++;
    if (o_data !== 32'h00FF48B7) begin
      errors++;
      $display("FAIL directed o_data: got %h want 00FF48B7", o_data);
    end
    checks++;
    if (o_error_code !== 8'd0) begin
      errors++;
      $display("FAIL directed o_error_code: got %0d want 0", o_error_code);
    end
    checks++;
    if (lat < 558 * FreqMhz || lat > 562 * FreqMhz) begin
      errors++;
      $display("FAIL directed ready latency: got %0d clk want about %0d", lat, 560 * FreqMhz);
    end
  endtask

  task automatic test_random_frames;
    logic [7:0] a;
    logic [7:0] c;
    logic [31:0] w;
    int r0;
    int stop_cyc;
    for (int n = 0; n < 2; n++) begin
      a = 8'($urandom);
      c = 8'($urandom);
      w = nec_word(a, ~a, c, ~c);
      r0 = ready_cnt;
      send_frame(w, 15, 32, stop_cyc);
      exp_data = w;
      checks++;
      if (ready_cnt - r0 != 1) begin
        errors++;
        $display("FAIL random%0d ready count: got %0d want 1", n, ready_cnt - r0);
      end
      checks++;
      if (o_data !== w) begin
        errors++;
        $display("FAIL random%0d o_data: got %h want %h", n, o_data, w);
      end
      checks++;
      if (o_error_code !== 8'd0) begin
        errors++;
        $display("FAIL random%0d o_error_code: got %0d want 0", n, o_error_code);
      end
    end
  endtask

  task automatic test_repeat;
    int r0;
    int p0;
    r0 = ready_cnt;
    p0 = rep_cnt;
    send_repeat(10);
    checks++;
    if (rep_cnt - p0 != 1) begin
      errors++;
      $display("FAIL repeat count: got %0d want 1", rep_cnt - p0);
    end
    checks++;
    if (ready_cnt - r0 != 0) begin
      errors++;
      $display("FAIL repeat ready count: got %0d want 0", ready_cnt - r0);
    end
    checks++;
    if (o_data !== exp_data) begin
      errors++;
      $display("FAIL repeat o_data: got %h want %h", o_data, exp_data);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_data = 32'h0;
    wait_us(100);
    p0 = rep_cnt;
    send_repeat(10);
    checks++;
    if (rep_cnt - p0 != 0) begin
      errors++;
      $display("FAIL repeat after reset count: got %0d want 0", rep_cnt - p0);
    end
    checks++;
    if (o_idle !== 1'b1) begin
      errors++;
      $display("FAIL repeat after reset o_idle: got %b want 1", o_idle);
    end
  endtask

  task automatic test_lead_mark_err;
    int r0;
    int stop_cyc;
    logic [7:0] c;
    logic [31:0] w;
    r0 = ready_cnt;
    ir = 1'b0;
    wait_us(6000);
    ir = 1'b1;
    wait_us(10);
    checks++;
    if (o_error_code !== 8'd1) begin
      errors++;
      $display("FAIL leadmark o_error_code: got %0d want 1", o_error_code);
    end
    wait_us(4990);
    send_frame(nec_word(8'h00, 8'hFF, 8'h00, 8'hFF), 0, 32, stop_cyc);
    checks++;
    if (ready_cnt - r0 != 0) begin
      errors++;
      $display("FAIL leadmark ignored ready count: got %0d want 0", ready_cnt - r0);
    end
    checks++;
    if (o_data !== exp_data || o_error_code !== 8'd1) begin
      errors++;
      $display("FAIL leadmark ignored state: got %h/%0d want %h/1", o_data, o_error_code,
               exp_data);
    end
    checks++;
    if (o_idle !== 1'b0) begin
      errors++;
      $display("FAIL leadmark recover o_idle: got %b want 0", o_idle);
    end
    wait_us(10500);
    c = 8'($urandom);
    w = nec_word(8'hA5, 8'h5A, c, ~c);
    r0 = ready_cnt;
    send_frame(w, 10, 32, stop_cyc);
    exp_data = w;
    checks++;
    if (ready_cnt - r0 != 1 || o_data !== w || o_error_code !== 8'd0) begin
      errors++;
      $display("FAIL leadmark recovery frame: got cnt %0d data %h err %0d want 1 %h 0",
               ready_cnt - r0, o_data, o_error_code, w);
    end
  endtask

  task automatic test_timeout;
    int r0;
    int t0;
    int tcyc;
    int us;
    logic found;
    r0 = ready_cnt;
    found = 1'b0;
    tcyc = 0;
    pulse(9000, 4500);
    ir = 1'b0;
    t0 = cyc;
    for (int k = 0; k < 15000 * FreqMhz; k++) begin
      @(negedge clk);
      if (!found && o_error_code === 8'd5) begin
        found = 1'b1;
        tcyc = cyc;
      end
    end
    ir = 1'b1;
    us = (tcyc - t0) / FreqMhz;
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL timeout code: got %0d want 5 within 15000 us", o_error_code);
    end else if (us < 11995 || us > 12010) begin
      checks++;
      errors++;
      $display("FAIL timeout instant: got %0d us want 12000", us);
    end
    checks++;
    if (ready_cnt - r0 != 0 || o_data !== exp_data) begin
      errors++;
      $display("FAIL timeout side effects: got cnt %0d data %h want 0 %h", ready_cnt - r0,
               o_data, exp_data);
    end
    wait_us(10500);
  endtask

  task automatic test_checksum;
    int r0;
    int stop_cyc;
    logic [31:0] w;
    w = nec_word(8'h00, 8'hFF, 8'h12, 8'hEC);
    r0 = ready_cnt;
    send_frame(w, 10, 32, stop_cyc);
`ifdef NEC_CHECK_EN
    checks++;
    if (o_error_code !== 8'd6) begin
      errors++;
      $display("FAIL checksum o_error_code: got %0d want 6", o_error_code);
    end
    checks++;
    if (ready_cnt - r0 != 0 || o_data !== exp_data) begin
      errors++;
      $display("FAIL checksum output: got cnt %0d data %h want 0 %h", ready_cnt - r0, o_data,
               exp_data);
    end
    wait_us(10500);
`else
    exp_data = w;
    checks++;
    if (ready_cnt - r0 != 1) begin
      errors++;
      $display("FAIL nochecksum ready count: got %0d want 1", ready_cnt - r0);
    end
    checks++;
    if (o_data[7:0] !== 8'h37 || o_data !== w) begin
      errors++;
      $display("FAIL nochecksum o_data: got %h want %h", o_data, w);
    end
    checks++;
    if (o_error_code !== 8'd0) begin
      errors++;
      $display("FAIL nochecksum o_error_code: got %0d want 0", o_error_code);
    end
`endif
  endtask

  task automatic test_reset_mid;
    int r0;
    int stop_cyc;
    logic [7:0] a;
    logic [31:0] w;
    a = 8'($urandom);
    w = nec_word(a, ~a, 8'h3C, 8'hC3);
    send_frame(w, 10, 17, stop_cyc);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("midreset");
    rst_n = 1'b1;
    ir = 1'b1;
    exp_data = 32'h0;
    wait_us(2000);
    r0 = ready_cnt;
    send_frame(w, 10, 32, stop_cyc);
    exp_data = w;
    checks++;
    if (ready_cnt - r0 != 1 || o_data !== w || o_error_code !== 8'd0) begin
      errors++;
      $display("FAIL midreset next frame: got cnt %0d data %h err %0d want 1 %h 0",
               ready_cnt - r0, o_data, o_error_code, w);
    end
  endtask

  initial begin
    test_reset();
    test_directed_frame();
    test_random_frames();
    test_repeat();
    test_lead_mark_err();
    test_timeout();
    test_checksum();
    test_reset_mid();
    checks++;
    if (both_cnt != 0) begin
      errors++;
      $display("FAIL ready_and_repeat overlap: got %0d cycles want 0", both_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nec_ir_rx.md
Name: nec_ir_rx

Overview:
- NEC infrared remote receiver.
- Sits upstream of the SoC keypad-emulation FSM; that FSM turns decoded frames into keyboard matrix writes.
- Samples the demodulated IR receiver output, measures mark/space widths in microseconds, and assembles 32-bit frames.
- Reports each completed frame with a one-cycle ready pulse, flags NEC repeat codes, and reports protocol errors with a code.

Parameters:
- CLOCK_FREQ_MHZ, 50: clk ticks per microsecond; sets the prescaler.
- TOLERANCE_PCT, 25: allowed ± deviation of every measured width from its nominal value.
- TIMEOUT_US, 12000: maximum single mark/space width before a timeout error.
- GAP_US, 10000: continuous idle (high) time required to leave error recovery.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- ir  in  1  raw demodulator output; idle high, mark = low; asynchronous
- o_data  out  32  last valid frame; first received bit at [31], command byte bit-reversed at [15:8]
- o_idle  out  1  high while in S_IDLE
- o_data_ready  out  1  one-cycle pulse when o_data updates
- o_repeat  out  1  one-cycle pulse on a valid repeat code
- o_error_code  out  8  last error: 0 none, 1 leader mark, 2 leader space, 3 bit mark, 4 bit space, 5 timeout, 6 checksum

Behaviour:
- Reset values: o_data=0, o_idle=1, o_data_ready=0, o_repeat=0, o_error_code=0; synchroniser flops=1; state=S_IDLE; frame_valid=0.
- Input path: 2-FF synchroniser, then edge detect on the second flop.
  - Edge latency from ir to the FSM is 3 clk.
- Width timer:
  - Prescaler counts 0..CLOCK_FREQ_MHZ-1 and emits a us_tick.
  - 16-bit width counter increments on each us_tick, saturates at 0xFFFF, and clears on every synchronised edge.
  - Prescaler also clears on every edge.
- Window test: width w matches nominal N when N*(100-TOLERANCE_PCT)/100 ≤ w ≤ N*(100+TOLERANCE_PCT)/100. Bounds are compile-time constants.
- Nominal widths (µs): leader mark 9000, data leader space 4500, repeat leader space 2250, bit mark 560, zero space 560, one space 1690.
- FSM. Each width is evaluated at the edge that ends it.
  - S_IDLE: falling edge -> S_LEAD_MARK.
  - S_LEAD_MARK: rising edge; 9000 in window -> S_LEAD_SPACE, else error 1.
  - S_LEAD_SPACE: falling edge.
    - 4500 in window -> S_BIT_MARK, with bit_cnt=0.
    - 2250 in window -> S_REP_MARK.
    - Otherwise error 2.
  - S_BIT_MARK: rising edge.
    - 560 in window, bit_cnt<32 -> S_BIT_SPACE.
    - 560 in window, bit_cnt==32 -> frame complete.
    - Otherwise error 3.
  - S_BIT_SPACE: falling edge; the 560 window shifts in 0, the 1690 window shifts in 1.
    - shift = {shift[30:0], bit}, bit_cnt++ -> S_BIT_MARK.
    - Neither window -> error 4.
  - S_REP_MARK: rising edge, 560 in window -> o_repeat pulses only if frame_valid=1; then S_IDLE. Out of window -> error 3.
  - Frame complete: o_data<=shift, o_data_ready pulses for 1 clk, o_error_code<=0, frame_valid<=1, -> S_IDLE.
  - Any state except S_IDLE/S_RECOVER: width counter reaching TIMEOUT_US -> error 5.
  - Error entry:
    - o_error_code<=code, frame_valid<=0, shift/bit_cnt cleared, -> S_RECOVER.
    - No ready or repeat pulse is issued for the aborted frame.
  - S_RECOVER: exit to S_IDLE once the line has been continuously high for GAP_US. Any falling edge restarts the gap count.
- o_data holds its value across errors and repeats.
- o_data_ready and o_repeat are never high in the same cycle.
- An edge that arrives in the same cycle as a timeout: the timeout takes priority.
- rst_n low mid-frame: all state returns to reset values on the next clk edge; the partial frame is discarded.

Optional Feature:
- Macro: NEC_CHECK_EN.
- With NEC_CHECK_EN: at frame complete, require shift[15:8] == ~shift[7:0].
  - Mismatch -> error 6; no o_data_ready; o_data unchanged.
- Without NEC_CHECK_EN: no check; error code 6 is never produced.

Decomposition:
- Package nec_ir_pkg contains:
  - state enum;
  - error-code localparams (ERR_NONE..ERR_CHECKSUM);
  - nominal width constants;
  - the window-bound function.
- Sub-module ir_pulse_timer contains the synchroniser, edge detect, µs prescaler, and saturating width counter.
  - Outputs: level, rise, fall, width_us.

Test Plan (CLOCK_FREQ_MHZ=4 for speed):
- Send address 0x00, command 0x12 (LSB-first bytes: 00 FF 12 ED) -> o_data_ready pulses once ~560 µs after the first edge of the stop mark, with o_data=32'h00FF48B7 and o_error_code=0.
- Send a valid frame, then a repeat code (9000/2250/560) -> one o_repeat pulse and o_data unchanged. Then reset, then a repeat alone -> no o_repeat.
- Leader mark 6000 µs -> o_error_code=1, no ready pulse. A new frame sent only 5 ms later is ignored; after a 10 ms gap the next frame decodes.
- Line held low for 15 ms after the leader space -> o_error_code=5 at 12000 µs.
- With NEC_CHECK_EN, a frame whose last byte is 0xEC -> o_error_code=6, no pulse. Without NEC_CHECK_EN, the same frame -> ready pulse, o_data[7:0]=0x37.
- Assert rst_n low during bit 17 -> all outputs return to reset values; a following complete frame decodes correctly.
